// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline (IF, ID, EX, MEM, WB).
// It covers load-use hazards, the MDU start/done handshake, data-memory wait
// states and taken-branch flushes. It also keeps saturating stall/flush counters.
//
// state  | meaning
// IDLE   | no MDU op in flight; an MDU op in EX stalls and launches
// LAUNCH | mdu_start pulse cycle, EX held
// BUSY   | waiting for mdu_done, EX held until the done cycle
// HELD   | done arrived under a memory wait; release once the wait clears
module pipeline_hazard_ctrl #(
  parameter int REG_LOG = 5,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*REG_LOG-1:0] rs_ID,
  input  logic [2:0]           rs_use_ID,
  input  logic [REG_LOG-1:0]   rd_EX,
  input  logic                 mem_read_EX,
  input  logic                 mdu_op_EX,
  input  logic                 mdu_done,
  input  logic                 dmem_req_MEM,
  input  logic                 dmem_ready,
  input  logic                 br_taken_EX,
  output logic                 stall_IF,
  output logic                 stall_ID,
  output logic                 stall_EX,
  output logic                 stall_MEM,
  output logic                 flush_ID,
  output logic                 flush_EX,
  output logic                 flush_MEM,
  output logic                 flush_WB,
  output logic                 mdu_start,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    HELD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             mdu_start_q, mdu_start_d;
  logic             ret_q, ret_d;
  logic             stall_ex_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_wait;
  logic src_hit;
  logic load_use;
  logic relaunch_blk;
  logic mdu_stall;
  logic br_flush;

  assign mem_wait = dmem_req_MEM & ~dmem_ready;

  // Compare each source that is actually read against the EX load destination.
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rs_use_ID[i] && (rs_ID[(3-i)*REG_LOG-1 -: REG_LOG] == rd_EX))
        src_hit = 1'b1;
    end
  end

  assign load_use = mem_read_EX & (|rd_EX) & src_hit;

  // The cycle right after an MDU op completes must not re-launch the same op if EX was held.
  assign relaunch_blk = ret_q & stall_ex_q;

  assign mdu_stall = (state_q == LAUNCH) |
                     ((state_q == BUSY) & ~mdu_done) |
                     ((state_q == IDLE) & mdu_op_EX & ~relaunch_blk);

  // Prioritised stall/flush decode: mem wait, then MDU, then load-use, then branch.
  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    flush_MEM = 1'b0;
    flush_WB  = 1'b0;
    br_flush  = 1'b0;
    if (mem_wait) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      stall_EX  = 1'b1;
      stall_MEM = 1'b1;
      flush_WB  = 1'b1;
    end else if (mdu_stall) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      stall_EX  = 1'b1;
      flush_MEM = 1'b1;
    end else if (load_use) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      flush_EX  = 1'b1;
    end else if (br_taken_EX) begin
      flush_ID  = 1'b1;
      flush_EX  = 1'b1;
      br_flush  = 1'b1;
    end
  end

  // Next-state logic for the MDU handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (mdu_op_EX && !mem_wait && !relaunch_blk) state_d = LAUNCH;
      LAUNCH: state_d = BUSY;
      BUSY:   if (mdu_done) state_d = mem_wait ? HELD : IDLE;
      HELD:   if (!mem_wait) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mdu_start_d = (state_q == IDLE) && (state_d == LAUNCH);
    ret_d       = ((state_q == BUSY) || (state_q == HELD)) && (state_d == IDLE);
  end

  // MDU FSM state with its registered launch pulse and re-launch guard history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mdu_start_q <= 1'b0;
      ret_q       <= 1'b0;
      stall_ex_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mdu_start_q <= mdu_start_d;
      ret_q       <= ret_d;
      stall_ex_q  <= stall_EX;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_IF && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_flush && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mdu_start = mdu_start_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LoongArch-32 pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards that forwarding cannot cover and sequences the multi-cycle multiply/divide unit (MDU) through a start/done handshake.
- Also handles data-memory wait states and taken-branch flushes.
- Drives per-stage hold and bubble controls and exposes saturating stall/flush performance counters.

Parameters:
- REG_LOG, 5: register index width.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs_ID  in  3*REG_LOG  source regs of the ID instruction, packed {rs0, rs1, rs2}.
- rs_use_ID  in  3  per-source "actually read" flags, bit i for rs_i (bit0 = rs0).
- rd_EX  in  REG_LOG  destination reg of the EX instruction.
- mem_read_EX  in  1  EX instruction is a load.
- mdu_op_EX  in  1  EX instruction needs the MDU.
- mdu_done  in  1  MDU result valid; single-cycle pulse.
- dmem_req_MEM  in  1  MEM stage has an outstanding data access.
- dmem_ready  in  1  data memory completes the access this cycle.
- br_taken_EX  in  1  branch/jump resolved taken in EX.
- stall_IF, stall_ID, stall_EX, stall_MEM  out  1 each  hold the PC / stage register.
- flush_ID  out  1  clear the IF/ID register.
- flush_EX  out  1  clear ID/EX (bubble into EX).
- flush_MEM  out  1  clear EX/MEM (bubble into MEM).
- flush_WB  out  1  clear MEM/WB (bubble into WB).
- mdu_start  out  1  one-cycle MDU launch pulse (registered).
- stall_cnt  out  CNT_W  cycles with stall_IF=1; saturates at all-ones.
- flush_cnt  out  CNT_W  cycles with br_taken flush applied; saturates.

Behaviour:
- FSM states: IDLE, LAUNCH, BUSY, HELD. Reset puts the FSM in IDLE, clears both counters and drives mdu_start=0. All other outputs are combinational and evaluate to 0 with all inputs low.
- mem_wait = dmem_req_MEM & ~dmem_ready.
- load_use = mem_read_EX & |rd_EX & OR over i of (rs_use_ID[i] & rs_i == rd_EX).
- Priority, highest first: mem_wait, then MDU, then load_use, then branch.
- mem_wait:
  - stall_IF, stall_ID, stall_EX, stall_MEM = 1; flush_WB = 1.
  - All other flushes = 0.
- MDU condition (state in {LAUNCH, BUSY}, or IDLE with mdu_op_EX=1), when not mem_wait:
  - stall_IF, stall_ID, stall_EX = 1; flush_MEM = 1.
- load_use, when neither of the above applies:
  - stall_IF, stall_ID = 1; flush_EX = 1.
  - Lasts exactly one cycle: the load advances to MEM and forwarding covers the rest.
- Branch (br_taken_EX), when none of the above applies:
  - flush_ID = 1, flush_EX = 1; no stalls.
  - A branch held by any stall is acted on in the first unstalled cycle. A branch never causes a flush while EX is held.
- FSM transitions:
  - IDLE to LAUNCH: mdu_op_EX=1 & ~mem_wait. mdu_start=1 on the next cycle (the LAUNCH cycle).
  - LAUNCH to BUSY: unconditional.
  - BUSY to IDLE: mdu_done & ~mem_wait. That cycle releases EX: no MDU stall, flush_MEM=0.
  - BUSY to HELD: mdu_done & mem_wait. The result must be captured by the MDU.
  - HELD to IDLE: ~mem_wait. The HELD cycle itself applies no MDU stall.
  - The FSM never returns to LAUNCH for the same EX instruction. After IDLE, mdu_op_EX refers to the next instruction only once EX has advanced. A 1-cycle IDLE guard applies: re-launch is allowed only when the previous cycle had stall_EX=0.
- mdu_done outside BUSY is ignored.
- Reset asserted mid-operation (any state) returns to IDLE immediately and abandons the MDU op. mdu_start is never asserted during or in the cycle after reset.
- Counters:
  - stall_cnt increments by 1 every cycle stall_IF=1.
  - flush_cnt increments every cycle the branch flush is applied.
  - Both hold at 2^CNT_W-1 once reached.

Test Plan:
- Load-use: mem_read_EX=1, rd_EX=5, rs_ID={5,0,0}, rs_use_ID=3'b001 -> one cycle of stall_IF=stall_ID=flush_EX=1, then 0. Same stimulus with rd_EX=0, or with rs_use_ID=0 -> no stall.
- MDU: mdu_op_EX=1 at cycle 0 -> mdu_start=1 only at cycle 1; stall_IF/ID/EX=1 and flush_MEM=1 for cycles 0..4; mdu_done at cycle 5 -> all stalls 0 at cycle 5; stall_cnt=5.
- MDU plus mem wait: mdu_done arrives during dmem_req_MEM=1, dmem_ready=0 -> FSM enters HELD, all four stall_* and flush_WB=1; dmem_ready=1 -> next cycle IDLE with no stall, no second mdu_start.
- Branch under stall: br_taken_EX=1 while mem_wait lasts 3 cycles -> flush_ID/EX=0 throughout; flush_ID=flush_EX=1 in the first unstalled cycle; flush_cnt=1.
- Reset mid-BUSY: assert rst two cycles after mdu_start -> FSM IDLE, counters 0, all outputs 0 while inputs are low; no mdu_start in the cycle after release.
- Saturation: with CNT_W=4, hold mem_wait for 20 cycles -> stall_cnt stops at 15.
